// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_pkg
// Description : Shared function-select and sweep FSM state enumerations.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_pkg;

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_MAJ  = 3'd6,
        MODE_MIN  = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage : tt_pkg
`default_nettype wire

// File: rtl/tt_func.sv
`default_nettype none
// ============================================================================
// Module      : tt_func
// Description : Combinational N_IN-input boolean function selected by mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_func
    import tt_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  mode_e             mode_i,
    input  logic [N_IN-1:0]   ops_i,
    output logic              f_o
);

    // Majority threshold: strictly more than half of the operands are 1.
    localparam int HALF = N_IN / 2;

    int w_cnt;

    always_comb begin
        w_cnt = 0;
        for (int k = 0; k < N_IN; k++) begin
            w_cnt = w_cnt + int'(ops_i[k]);
        end
    end

    always_comb begin
        f_o = 1'b0;
        case (mode_i)
            MODE_AND:  f_o =  (&ops_i);
            MODE_OR:   f_o =  (|ops_i);
            MODE_XOR:  f_o =  (^ops_i);
            MODE_NAND: f_o = ~(&ops_i);
            MODE_NOR:  f_o = ~(|ops_i);
            MODE_XNOR: f_o = ~(^ops_i);
            MODE_MAJ:  f_o =  (w_cnt > HALF);
            MODE_MIN:  f_o = ~(w_cnt > HALF);
            default:   f_o = 1'b0;
        endcase
    end

endmodule : tt_func
`default_nettype wire

// File: rtl/truth_table_engine.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_engine
// Description : Single-shot function evaluator plus truth-table sweep engine.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_engine
    import tt_pkg::*;
#(
    parameter  int N_IN = 3,
    localparam int ROWS = 2**N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        mode,
    input  logic              start,
    input  logic [N_IN-1:0]   ext_in,
    input  logic              ext_valid,
    output logic              result,
    output logic              result_valid,
    output logic              busy,
    output logic              done,
    output logic [ROWS-1:0]   table_out,
    output logic [N_IN:0]     ones_count
);

    localparam logic [N_IN-1:0] ROW_LAST = N_IN'(ROWS - 1);

    state_e             state_q,  state_d;
    logic [N_IN-1:0]    row_q,    row_d;
    mode_e              mode_q,   mode_d;
    logic [ROWS-1:0]    table_q,  table_d;
    logic [N_IN:0]      ones_q,   ones_d;
    logic               result_q, result_valid_q;

    logic               w_ext_f;
    logic               w_sweep_f;

    tt_func #(.N_IN(N_IN)) u_func_ext (
        .mode_i (mode_e'(mode)),
        .ops_i  (ext_in),
        .f_o    (w_ext_f)
    );

    // The sweep path uses the mode captured at start, never the live input.
    tt_func #(.N_IN(N_IN)) u_func_sweep (
        .mode_i (mode_q),
        .ops_i  (row_q),
        .f_o    (w_sweep_f)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        mode_d  = mode_q;
        table_d = table_q;
        ones_d  = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode_e'(mode);
                    table_d = '0;
                    ones_d  = '0;
                    row_d   = '0;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                table_d[row_q] = w_sweep_f;
                ones_d         = ones_q + (N_IN+1)'(w_sweep_f);
                if (row_q == ROW_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    row_d = row_q + N_IN'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            row_q          <= '0;
            mode_q         <= MODE_AND;
            table_q        <= '0;
            ones_q         <= '0;
            result_q       <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            mode_q         <= mode_d;
            table_q        <= table_d;
            ones_q         <= ones_d;
            result_valid_q <= ext_valid;
            if (ext_valid) begin
                result_q <= w_ext_f;
            end
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FINISH);
    assign table_out    = table_q;
    assign ones_count   = ones_q;

endmodule : truth_table_engine
`default_nettype wire

// File: tb/tb_truth_table_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_engine
// Description : Scoreboard bench for truth_table_engine at N_IN=3 and N_IN=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_engine;

    typedef struct {
        logic [63:0] tbl;
        int          ones;
        int          cyc;
    } sw_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mode;
    logic        start;
    logic [2:0]  ext_in;
    logic        ext_valid;
    logic        result, result_valid, busy, done;
    logic [7:0]  table_out;
    logic [3:0]  ones_count;

    logic [2:0]  mode6;
    logic        start6;
    logic [5:0]  ext_in6;
    logic        ext_valid6;
    logic        result6, result_valid6, busy6, done6;
    logic [63:0] table6;
    logic [6:0]  ones6;

    int tests = 0;
    int fails = 0;
    int bcnt3 = 0;
    int bcnt6 = 0;

    bit  rq[$];
    sw_t sq3[$];
    sw_t sq6[$];
    bit  e3;
    sw_t s3, s6;

    truth_table_engine #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start),
        .ext_in(ext_in), .ext_valid(ext_valid),
        .result(result), .result_valid(result_valid), .busy(busy), .done(done),
        .table_out(table_out), .ones_count(ones_count)
    );

    truth_table_engine #(.N_IN(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .start(start6),
        .ext_in(ext_in6), .ext_valid(ext_valid6),
        .result(result6), .result_valid(result_valid6), .busy(busy6), .done(done6),
        .table_out(table6), .ones_count(ones6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever a DUT presents an output.
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt3 = 0;
            bcnt6 = 0;
        end else begin
            if (result_valid) begin
                if (rq.size() == 0) chk("unexpected_result_valid", 64'(result_valid), 64'(0));
                else begin
                    e3 = rq.pop_front();
                    chk("result", 64'(result), 64'(e3));
                end
            end
            if (busy) bcnt3++;
            if (done) begin
                if (sq3.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
                else begin
                    s3 = sq3.pop_front();
                    chk("table_out", 64'(table_out), s3.tbl);
                    chk("ones_count", 64'(ones_count), 64'(s3.ones));
                    chk("busy_cycles", 64'(bcnt3), 64'(s3.cyc));
                end
                bcnt3 = 0;
            end
            if (!busy) bcnt3 = 0;

            if (busy6) bcnt6++;
            if (done6) begin
                if (sq6.size() == 0) chk("unexpected_done6", 64'(done6), 64'(0));
                else begin
                    s6 = sq6.pop_front();
                    chk("table_out6", table6, s6.tbl);
                    chk("ones_count6", 64'(ones6), 64'(s6.ones));
                    chk("busy_cycles6", 64'(bcnt6), 64'(s6.cyc));
                end
                bcnt6 = 0;
            end
            if (!busy6) bcnt6 = 0;
        end
    end

    task automatic wait_done3(input int max);
        int i;
        i = 0;
        while (sq3.size() != 0 && i < max) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk("sweep3_pending", 64'(sq3.size()), 64'(0));
    endtask

    task automatic wait_done6(input int max);
        int i;
        i = 0;
        while (sq6.size() != 0 && i < max) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk("sweep6_pending", 64'(sq6.size()), 64'(0));
    endtask

    task automatic sweep3(input logic [2:0] m, input logic [7:0] tbl, input int ones);
        mode  = m;
        start = 1'b1;
        sq3.push_back('{tbl: 64'(tbl), ones: ones, cyc: 9});
        tick();
        start = 1'b0;
        wait_done3(40);
    endtask

    task automatic ext(input logic [2:0] m, input logic [2:0] v, input bit exp);
        mode      = m;
        ext_in    = v;
        ext_valid = 1'b1;
        rq.push_back(exp);
        tick();
        ext_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_table"},  64'(table_out),    64'(0));
        chk({tag, "_ones"},   64'(ones_count),   64'(0));
        chk({tag, "_busy"},   64'(busy),         64'(0));
        chk({tag, "_done"},   64'(done),         64'(0));
        chk({tag, "_result"}, 64'(result),       64'(0));
        chk({tag, "_rv"},     64'(result_valid), 64'(0));
    endtask

    function automatic logic [63:0] min6_table();
        logic [63:0] t;
        logic [5:0]  r;
        t = '0;
        for (int i = 0; i < 64; i++) begin
            r    = 6'(i);
            t[i] = ($countones(r) <= 3);
        end
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mode = 3'd0; start = 1'b0; ext_in = 3'd0; ext_valid = 1'b0;
        mode6 = 3'd0; start6 = 1'b0; ext_in6 = 6'd0; ext_valid6 = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");

        // First start accepted on the first edge after release; AND sweep.
        rst_n = 1'b1;
        mode  = 3'd0;
        start = 1'b1;
        sq3.push_back('{tbl: 64'h80, ones: 1, cyc: 9});
        tick();
        chk("busy_after_start", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done3(40);
        repeat (3) tick();
        chk("hold_table", 64'(table_out), 64'h80);
        chk("hold_ones", 64'(ones_count), 64'(1));

        sweep3(3'd6, 8'hE8, 4);
        sweep3(3'd2, 8'h96, 4);

        // NOR sweep with mode change and ignored start mid-sweep.
        mode  = 3'd4;
        start = 1'b1;
        sq3.push_back('{tbl: 64'h01, ones: 1, cyc: 9});
        tick();
        start = 1'b0;
        tick(); tick();
        mode  = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done3(40);
        repeat (4) tick();
        chk("no_queued_start", 64'(busy), 64'(0));

        ext(3'd0, 3'b111, 1'b1);
        ext(3'd0, 3'b110, 1'b0);
        ext(3'd1, 3'b000, 1'b0);
        ext(3'd3, 3'b110, 1'b1);
        ext(3'd4, 3'b000, 1'b1);
        ext(3'd6, 3'b100, 1'b0);
        ext(3'd7, 3'b011, 1'b0);
        ext(3'd6, 3'b011, 1'b1);
        ext(3'd2, 3'b011, 1'b0);
        repeat (3) tick();
        chk("result_hold", 64'(result), 64'(0));
        chk("result_valid_low", 64'(result_valid), 64'(0));

        // Single evaluation concurrent with a MAJ sweep.
        mode  = 3'd6;
        start = 1'b1;
        sq3.push_back('{tbl: 64'hE8, ones: 4, cyc: 9});
        tick();
        start = 1'b0;
        tick();
        ext(3'd5, 3'b101, 1'b1);
        tick();
        wait_done3(40);

        // Simultaneous start and ext_valid.
        mode      = 3'd2;
        ext_in    = 3'b111;
        start     = 1'b1;
        ext_valid = 1'b1;
        sq3.push_back('{tbl: 64'h96, ones: 4, cyc: 9});
        rq.push_back(1'b1);
        tick();
        start     = 1'b0;
        ext_valid = 1'b0;
        wait_done3(40);

        // Reset while processing row 4 of an OR sweep.
        mode  = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("partial_table", 64'(table_out), 64'h0E);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        sweep3(3'd7, 8'h17, 4);

        // N_IN=6 MIN sweep with an ignored start during busy.
        mode6  = 3'd7;
        start6 = 1'b1;
        sq6.push_back('{tbl: min6_table(), ones: 42, cyc: 65});
        tick();
        start6 = 1'b0;
        repeat (10) tick();
        mode6  = 3'd0;
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        wait_done6(120);
        repeat (5) tick();
        chk("busy6_after_done", 64'(busy6), 64'(0));
        chk("hold_ones6", 64'(ones6), 64'(42));

        chk("result_queue_empty", 64'(rq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_truth_table_engine
`default_nettype wire

// File: doc/truth_table_engine.md
TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, giving the number of function inputs, legal range 2..6.
REQ-002 The block SHALL have derived constant ROWS = 2**N_IN, the truth-table row count.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 mode  input  3  function select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 MAJ, 7 MIN.
REQ-006 start  input  1  sweep request, sampled only in IDLE.
REQ-007 ext_in  input  N_IN  operand vector for single evaluation.
REQ-008 ext_valid  input  1  qualifies ext_in for single evaluation.
REQ-009 result  output  1  registered single-evaluation result.
REQ-010 result_valid  output  1  one-cycle pulse qualifying result.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 table_out  output  ROWS  truth table; bit i = f(i), where bit 0 of i is the lowest operand.
REQ-014 ones_count  output  N_IN+1  number of 1 bits in table_out.

Function
REQ-015 MAJ SHALL be 1 when the count of 1 operands is strictly greater than N_IN/2; MIN SHALL be its complement.
REQ-016 AND, OR, XOR and their complements SHALL reduce across all N_IN operands.
REQ-017 Single evaluation: ext_valid high in cycle t SHALL produce result = f(mode, ext_in) and result_valid = 1 in cycle t+1, in any FSM state.
REQ-018 result SHALL hold its last value while result_valid is low.
REQ-019 The FSM SHALL have three states: IDLE, SWEEP and FINISH.
REQ-020 In IDLE, start = 1 SHALL latch mode, clear table_out and ones_count to 0, clear the row counter, and enter SWEEP.
REQ-021 In SWEEP, each cycle SHALL write bit [row] of table_out with f(latched mode, row), add that bit to ones_count, and increment row.
REQ-022 Exactly ROWS cycles SHALL be spent in SWEEP, and the row counter SHALL not wrap past ROWS-1.
REQ-023 After row ROWS-1, the FSM SHALL enter FINISH; FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-024 busy SHALL be 1 exactly in SWEEP and FINISH.
REQ-025 start while busy SHALL be ignored, with no queuing.
REQ-026 A mode change during a sweep SHALL not affect the sweep.
REQ-027 table_out and ones_count SHALL hold after done until the next accepted start.
REQ-028 Simultaneous start and ext_valid SHALL both be serviced independently.

Reset
REQ-029 rst_n low SHALL asynchronously force state to IDLE and row to 0.
REQ-030 rst_n low SHALL asynchronously force result, result_valid, busy, done, table_out and ones_count to 0.
REQ-031 Reset mid-sweep SHALL abort the sweep with no done pulse, and the partial table SHALL be discarded.
REQ-032 Reset release SHALL be synchronous-deassert safe; the first start is accepted on the first edge after release.

Structure
REQ-033 Shared package tt_pkg SHALL hold the mode enumeration and the FSM state enumeration.
REQ-034 One combinational sub-module tt_func(N_IN) SHALL compute f(mode, operands).
REQ-035 tt_func SHALL be instantiated twice: once for the ext path and once for the sweep path.

Verification
REQ-036 N_IN=3, mode=0, start pulse -> busy for 9 cycles, done pulse, table_out = 8'h80, ones_count = 1.
REQ-037 N_IN=3, mode=6 sweep -> table_out = 8'hE8, ones_count = 4; mode=2 sweep -> table_out = 8'h96, ones_count = 4.
REQ-038 N_IN=3, mode=4 sweep -> table_out = 8'h01; mode changed to 1 mid-sweep -> table_out still 8'h01.
REQ-039 ext_in = 3'b101 with mode=5, ext_valid pulse -> next cycle result = 1, result_valid = 1; concurrent sweep unaffected.
REQ-040 rst_n low at row 4 of a sweep -> all outputs 0 immediately, no done; a new start gives a correct full table.
REQ-041 N_IN=6, mode=7 sweep -> 64 SWEEP cycles, ones_count = 42 (rows with at most 3 ones), start during busy ignored.
